// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (instruction fetch / data) arbiter onto a single word
//               RAM with a one-cycle registered read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_ISSUE   = 2'd1;
  localparam logic [1:0] c_CAPTURE = 2'd2;
  localparam logic [1:0] c_RESPOND = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK = ~ADDR_WIDTH'(3);

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic                  r_gnt_d;
  logic                  r_last_d;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;
  logic                  w_grant;
  logic                  w_pick_d;
  logic [ADDR_WIDTH-1:0] w_sel_addr;

  // r_last_d resets to 1 so the IF port wins the first tie.
  assign w_grant    = (r_state == c_IDLE) && (if_req || d_req);
  assign w_pick_d   = d_req && (!if_req || !r_last_d);
  assign w_sel_addr = w_pick_d ? d_addr : if_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:    if (w_grant) w_next = c_ISSUE;
      c_ISSUE:   w_next = r_we ? c_RESPOND : c_CAPTURE;
      c_CAPTURE: w_next = c_RESPOND;
      c_RESPOND: w_next = c_IDLE;
      default:   w_next = c_IDLE;
    endcase
  end

  always_comb begin
    ram_cs = 1'b0;
    ram_we = 1'b0;
    ram_oe = 1'b0;
    if_ack = 1'b0;
    d_ack  = 1'b0;
    busy   = (r_state != c_IDLE);
    case (r_state)
      c_ISSUE: begin
        ram_cs = 1'b1;
        ram_we = r_we;
        ram_oe = !r_we;
      end
      c_CAPTURE: begin
        ram_cs = 1'b1;
        ram_oe = 1'b1;
      end
      c_RESPOND: begin
        if_ack = !r_gnt_d;
        d_ack  = r_gnt_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt_d    <= 1'b0;
      r_last_d   <= 1'b1;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_grant) begin
        r_gnt_d  <= w_pick_d;
        r_last_d <= w_pick_d;
        r_we     <= w_pick_d && d_we;
        r_addr   <= w_sel_addr & c_ALIGN_MASK;
        r_wdata  <= w_pick_d ? d_wdata : '0;
      end
      // RAM output is valid during CAPTURE; it lands in the grantee's register.
      if (r_state == c_CAPTURE) begin
        if (r_gnt_d) begin
          r_d_rdata <= ram_rdata;
        end else begin
          r_if_rdata <= ram_rdata;
        end
      end
    end
  end

  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, meaning the byte address width of the RAM.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the word width (4 bytes).
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports if_req in 1, if_addr in ADDR_WIDTH, if_ack out 1, if_rdata out DATA_WIDTH: the instruction-fetch port, read-only.
REQ-006 SHALL have ports d_req in 1, d_we in 1, d_addr in ADDR_WIDTH, d_wdata in DATA_WIDTH, d_ack out 1, d_rdata out DATA_WIDTH: the data port, read/write.
REQ-007 SHALL have ports ram_addr out ADDR_WIDTH, ram_wdata out DATA_WIDTH, ram_cs out 1, ram_we out 1, ram_oe out 1, ram_rdata in DATA_WIDTH: drive the shared word RAM (1-cycle registered read; data is driven only while cs=1, oe=1, we=0).
REQ-008 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, ISSUE, CAPTURE, RESPOND.
REQ-010 IDLE: if any req is high, SHALL grant one port, latch its address, we (0 for IF) and wdata, record the grantee, and go to ISSUE; otherwise stay in IDLE.
REQ-011 Arbitration: a single request SHALL be granted; on a tie, the port not granted last SHALL win; after reset the IF port SHALL win the first tie.
REQ-012 Latched address SHALL have bits [1:0] forced to 0 (word alignment); ram_addr SHALL carry the aligned address.
REQ-013 ISSUE: ram_cs=1, ram_addr/ram_wdata = latched values; read: ram_oe=1, ram_we=0, next CAPTURE; write: ram_we=1, ram_oe=0, next RESPOND.
REQ-014 CAPTURE (reads only): ram_cs=1, ram_oe=1, ram_we=0, ram_addr held; ram_rdata SHALL load the grantee's rdata register at the end of the cycle; next RESPOND.
REQ-015 RESPOND: ram_cs=ram_we=ram_oe=0; the grantee's ack SHALL be high for exactly this one cycle; next IDLE unconditionally.
REQ-016 Latency from the edge sampling req in IDLE to ack: read = 3 cycles (ack in the 3rd cycle after the sampling edge); write = 2 cycles.
REQ-017 if_rdata/d_rdata SHALL hold their value from the last completed read on that port until the next read completes on that port; writes SHALL NOT change d_rdata.
REQ-018 ack SHALL never be asserted for a port that was not granted, and never on both ports in the same cycle.
REQ-019 A requester SHALL hold req, addr, we, wdata stable until ack; req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-020 A request arriving while busy SHALL wait and SHALL be considered in the next IDLE cycle; no request SHALL be dropped.
REQ-021 ram_we and ram_oe SHALL never be high together; ram_we/ram_oe SHALL be 0 whenever ram_cs=0.

Reset
REQ-022 rst high SHALL immediately force state IDLE, all outputs 0 (ram_cs, ram_we, ram_oe, ram_addr, ram_wdata, if_ack, d_ack, if_rdata, d_rdata, busy) and last-grant so that IF wins the next tie.
REQ-023 Reset mid-transaction SHALL abort it with no ack; a write aborted in ISSUE may or may not have updated the RAM word.

Verification
REQ-024 RAM word 0x0010 = 0xE3A01005; if_req with if_addr 0x0010 -> ram_cs/ram_oe high 2 cycles, if_ack one cycle 3 cycles after sampling, if_rdata=0xE3A01005, ram_we never high.
REQ-025 d write 0xDEADBEEF to 0x0100, then d read 0x0100 -> write ack after 2 cycles with ram_we high 1 cycle; read returns d_rdata=0xDEADBEEF; if_rdata unchanged.
REQ-026 if_req and d_req held high continuously from reset -> grants IF, D, IF, D, ...; one ack every 4 cycles for reads, alternating ports, neither starved.
REQ-027 d read with d_addr 0x0103 -> ram_addr=0x0100 during ISSUE and CAPTURE.
REQ-028 rst pulsed during CAPTURE of an IF read -> no if_ack, all outputs 0 within the reset cycle; subsequent d read of 0x0100 completes normally with IF-first tie rule restored.
REQ-029 d_req raised while an IF read is in CAPTURE -> IF acked in RESPOND, d granted in following IDLE, d_ack arrives; no lost or duplicate acks.
